// File: rtl/mips_multicycle_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath/memory.
// master = controller side; slave = datapath side.
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       zero_ext;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       bad_instr;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_write, ir_write, reg_write, mem_write, iord, regdst, memtoreg,
               zero_ext, alusrca, alusrcb, pcsrc, alucontrol, bad_instr
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_write, ir_write, reg_write, mem_write, iord, regdst, memtoreg,
               zero_ext, alusrca, alusrcb, pcsrc, alucontrol, bad_instr
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: Moore selects per state, stalls in FETCH/MEMRD/MEMWR on mem_ready.
// Counts retired instructions; write enables are forced low while reset is held.
module mips_multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    mips_multicycle_ctrl_if.master bus,
    output logic [3:0]            state,
    output logic [CNT_W-1:0]      instr_count
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ORIEX  = 4'd10, S_IMMWB  = 4'd11,
        S_JUMP   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J   = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI  = 6'h08, OP_ORI = 6'h0D, OP_LW  = 6'h23, OP_SW  = 6'h2B;

    state_t cur, nxt;
    logic   retire;
    logic   pc_w, ir_w, reg_w, mem_w, bad;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur         <= S_FETCH;
            instr_count <= '0;
        end else begin
            cur <= nxt;
            if (retire)
                instr_count <= instr_count + CNT_W'(1);
        end
    end

    assign state = cur;

    always_comb begin
        nxt            = S_FETCH;
        retire         = 1'b0;
        pc_w           = 1'b0;
        ir_w           = 1'b0;
        reg_w          = 1'b0;
        mem_w          = 1'b0;
        bad            = 1'b0;
        bus.iord       = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.zero_ext   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.alucontrol = 3'b010;
        case (cur)
            S_FETCH: begin
                bus.alusrcb = 2'b01;
                pc_w        = bus.mem_ready;
                ir_w        = bus.mem_ready;
                nxt         = bus.mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                bus.alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW:   nxt = S_MEMADR;
                    OP_BEQ, OP_BNE: nxt = S_BRANCH;
                    OP_ADDI:        nxt = S_ADDIEX;
                    OP_ORI:         nxt = S_ORIEX;
                    OP_J:           nxt = S_JUMP;
                    OP_RTYPE: begin
                        case (bus.funct)
                            6'h20, 6'h22, 6'h24, 6'h25, 6'h2A: nxt = S_EXEC;
                            default:                           bad = 1'b1;
                        endcase
                    end
                    default:        bad = 1'b1;
                endcase
            end
            S_MEMADR: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                nxt         = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                bus.iord = 1'b1;
                nxt      = bus.mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                bus.memtoreg = 1'b1;
                reg_w        = 1'b1;
                retire       = 1'b1;
            end
            S_MEMWR: begin
                // Strobe stays up for the whole wait; retire on the completing cycle.
                bus.iord = 1'b1;
                mem_w    = 1'b1;
                retire   = bus.mem_ready;
                nxt      = bus.mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                bus.alusrca = 1'b1;
                nxt         = S_ALUWB;
                case (bus.funct)
                    6'h22:   bus.alucontrol = 3'b110;
                    6'h24:   bus.alucontrol = 3'b000;
                    6'h25:   bus.alucontrol = 3'b001;
                    6'h2A:   bus.alucontrol = 3'b111;
                    default: bus.alucontrol = 3'b010;
                endcase
            end
            S_ALUWB: begin
                bus.regdst = 1'b1;
                reg_w      = 1'b1;
                retire     = 1'b1;
            end
            S_BRANCH: begin
                bus.alusrca    = 1'b1;
                bus.alucontrol = 3'b110;
                bus.pcsrc      = 2'b01;
                pc_w           = (bus.op == OP_BNE) ? ~bus.zero : bus.zero;
                retire         = 1'b1;
            end
            S_ADDIEX: begin
                bus.alusrca = 1'b1;
                bus.alusrcb = 2'b10;
                nxt         = S_IMMWB;
            end
            S_ORIEX: begin
                bus.alusrca    = 1'b1;
                bus.alusrcb    = 2'b10;
                bus.zero_ext   = 1'b1;
                bus.alucontrol = 3'b001;
                nxt            = S_IMMWB;
            end
            S_IMMWB: begin
                reg_w  = 1'b1;
                retire = 1'b1;
            end
            S_JUMP: begin
                bus.pcsrc = 2'b10;
                pc_w      = 1'b1;
                retire    = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    assign bus.pc_write  = pc_w  & ~reset;
    assign bus.ir_write  = ir_w  & ~reset;
    assign bus.reg_write = reg_w & ~reset;
    assign bus.mem_write = mem_w & ~reset;
    assign bus.bad_instr = bad   & ~reset;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Drives two controllers (32-bit and 4-bit counters) with identical stimulus and checks each
// cycle against an instruction-level model that expands every instruction into its state walk.
module tb_mips_multicycle_ctrl;
    localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_BEQ = 6'h04, OP_BNE = 6'h05,
                           OP_ADDI = 6'h08, OP_ORI = 6'h0D, OP_LW = 6'h23, OP_SW = 6'h2B;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  op = 6'h00;
    logic [5:0]  funct = 6'h20;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [3:0]  state0, state1;
    logic [31:0] cnt0;
    logic [3:0]  cnt1;
    logic [31:0] exp_count = 32'd0;
    int          n_chk = 0;
    int          n_fail = 0;

    mips_multicycle_ctrl_if if0 ();
    mips_multicycle_ctrl_if if1 ();

    assign if0.op = op;  assign if0.funct = funct;  assign if0.zero = zero;  assign if0.mem_ready = mem_ready;
    assign if1.op = op;  assign if1.funct = funct;  assign if1.zero = zero;  assign if1.mem_ready = mem_ready;

    mips_multicycle_ctrl #(.CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(if0.master),
                                             .state(state0), .instr_count(cnt0));
    mips_multicycle_ctrl #(.CNT_W(4))  dut1 (.clk(clk), .reset(reset), .bus(if1.master),
                                             .state(state1), .instr_count(cnt1));

    always #5 clk = ~clk;

    function automatic bit funct_ok(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic bit instr_ok(input logic [5:0] o, input logic [5:0] f);
        case (o)
            OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
            OP_R:    return funct_ok(f);
            default: return 1'b0;
        endcase
    endfunction

    // Expected control word {pc_w, ir_w, reg_w, mem_w, iord, regdst, memtoreg, zero_ext,
    // alusrca, alusrcb, pcsrc, alucontrol, bad} for a given state and inputs.
    function automatic logic [16:0] exp_vec(input int st, input logic [5:0] o, input logic [5:0] f,
                                           input logic z, input logic mr, input logic rst);
        logic pw = 0, iw = 0, rw = 0, mw = 0, io = 0, rd = 0, mtr = 0, ze = 0, sa = 0, bd = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        logic [2:0] alu = 3'b010;
        case (st)
            0:  begin sb = 2'b01; pw = mr; iw = mr; end
            1:  begin sb = 2'b11; bd = !instr_ok(o, f); end
            2:  begin sa = 1; sb = 2'b10; end
            3:  io = 1;
            4:  begin mtr = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin
                    sa = 1;
                    alu = (f == 6'h22) ? 3'b110 : (f == 6'h24) ? 3'b000 :
                          (f == 6'h25) ? 3'b001 : (f == 6'h2A) ? 3'b111 : 3'b010;
                end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; alu = 3'b110; ps = 2'b01; pw = (o == OP_BNE) ? !z : z; end
            9:  begin sa = 1; sb = 2'b10; end
            10: begin sa = 1; sb = 2'b10; ze = 1; alu = 3'b001; end
            11: rw = 1;
            12: begin ps = 2'b10; pw = 1; end
            default: ;
        endcase
        if (rst) begin pw = 0; iw = 0; rw = 0; mw = 0; bd = 0; end
        return {pw, iw, rw, mw, io, rd, mtr, ze, sa, sb, ps, alu, bd};
    endfunction

    // One clock: apply inputs, check current-cycle outputs, advance past the next edge.
    task automatic do_cycle(input int exp_st, input int mr, input logic rst);
        logic [16:0] e, g0, g1;
        reset     = rst;
        mem_ready = (mr < 0) ? 1'($urandom_range(0, 1)) : mr[0];
        zero      = 1'($urandom_range(0, 1));
        #1;
        e  = exp_vec(exp_st, op, funct, zero, mem_ready, rst);
        g0 = {if0.pc_write, if0.ir_write, if0.reg_write, if0.mem_write, if0.iord, if0.regdst,
              if0.memtoreg, if0.zero_ext, if0.alusrca, if0.alusrcb, if0.pcsrc, if0.alucontrol, if0.bad_instr};
        g1 = {if1.pc_write, if1.ir_write, if1.reg_write, if1.mem_write, if1.iord, if1.regdst,
              if1.memtoreg, if1.zero_ext, if1.alusrca, if1.alusrcb, if1.pcsrc, if1.alucontrol, if1.bad_instr};
        n_chk++;
        if (state0 !== 4'(exp_st)) begin
            n_fail++; $display("FAIL state: got %0d expected %0d (op %h)", state0, exp_st, op);
        end
        n_chk++;
        if (g0 !== e) begin
            n_fail++; $display("FAIL ctrl st%0d: got %b expected %b (op %h funct %h)", exp_st, g0, e, op, funct);
        end
        n_chk++;
        if (g1 !== e) begin
            n_fail++; $display("FAIL ctrl4 st%0d: got %b expected %b", exp_st, g1, e);
        end
        n_chk++;
        if (cnt0 !== exp_count) begin
            n_fail++; $display("FAIL count: got %0d expected %0d", cnt0, exp_count);
        end
        n_chk++;
        if (cnt1 !== exp_count[3:0]) begin
            n_fail++; $display("FAIL count4: got %0d expected %0d", cnt1, exp_count[3:0]);
        end
        @(posedge clk); #1;
    endtask

    // Expand one instruction into its state walk: fw fetch waits, mw data-memory waits.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw);
        int q_st[$];
        int q_mr[$];
        op = o; funct = f;
        for (int i = 0; i < fw; i++) begin q_st.push_back(0); q_mr.push_back(0); end
        q_st.push_back(0); q_mr.push_back(1);
        q_st.push_back(1); q_mr.push_back(-1);
        if (instr_ok(o, f)) begin
            case (o)
                OP_R:   begin q_st.push_back(6); q_st.push_back(7); end
                OP_LW:  begin
                            q_st.push_back(2);
                            for (int i = 0; i < mw; i++) begin q_st.push_back(3); q_mr.push_back(-1); q_mr.push_back(0); q_mr.pop_back(); end
                            q_st.push_back(3); q_st.push_back(4);
                        end
                OP_SW:  begin
                            q_st.push_back(2);
                            for (int i = 0; i <= mw; i++) q_st.push_back(5);
                        end
                OP_BEQ, OP_BNE: q_st.push_back(8);
                OP_ADDI: begin q_st.push_back(9);  q_st.push_back(11); end
                OP_ORI:  begin q_st.push_back(10); q_st.push_back(11); end
                default: q_st.push_back(12);
            endcase
        end
        // Memory-ready per cycle: wait states see 0, the completing access sees 1, others random.
        q_mr.delete();
        for (int i = 0; i < q_st.size(); i++) begin
            if (q_st[i] == 0)
                q_mr.push_back((i == fw) ? 1 : 0);
            else if (q_st[i] == 3 || q_st[i] == 5)
                q_mr.push_back((i + 1 < q_st.size() && q_st[i + 1] == q_st[i]) ? 0 : 1);
            else
                q_mr.push_back(-1);
        end
        for (int i = 0; i < q_st.size(); i++)
            do_cycle(q_st[i], q_mr[i], 1'b0);
        if (instr_ok(o, f)) exp_count = exp_count + 32'd1;
    endtask

    task automatic test_reset();
        do_cycle(0, 1, 1'b1); exp_count = 32'd0;
        do_cycle(0, 1, 1'b1); exp_count = 32'd0;
    endtask

    task automatic test_add();
        run_instr(OP_R, 6'h20, 0, 0);
        run_instr(OP_R, 6'h22, 1, 0);
        run_instr(OP_R, 6'h2A, 0, 0);
    endtask

    task automatic test_lw_stall();
        run_instr(OP_LW, 6'($urandom), 0, 3);
        run_instr(OP_SW, 6'($urandom), 0, 2);
    endtask

    task automatic test_branches();
        run_instr(OP_BEQ, 6'($urandom), 0, 0);
        run_instr(OP_BNE, 6'($urandom), 0, 0);
        run_instr(OP_J,   6'($urandom), 0, 0);
        run_instr(OP_ADDI, 6'($urandom), 0, 0);
        run_instr(OP_ORI,  6'($urandom), 0, 0);
    endtask

    task automatic test_bad_instr();
        run_instr(6'h3F, 6'($urandom), 0, 0);
        run_instr(OP_R, 6'h3F, 0, 0);
    endtask

    task automatic test_random();
        logic [5:0] ops [10] = '{OP_R, OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ORI, OP_J, 6'h11};
        logic [5:0] fns [6]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h01};
        for (int n = 0; n < 40; n++)
            run_instr(ops[$urandom_range(0, 9)], fns[$urandom_range(0, 5)],
                      $urandom_range(0, 2), $urandom_range(0, 3));
    endtask

    task automatic test_reset_midwait();
        op = OP_SW; funct = 6'($urandom);
        do_cycle(0, 1, 1'b0);
        do_cycle(1, -1, 1'b0);
        do_cycle(2, -1, 1'b0);
        do_cycle(5, 0, 1'b0);
        do_cycle(5, 0, 1'b1); exp_count = 32'd0;
        do_cycle(0, 1, 1'b1); exp_count = 32'd0;
    endtask

    task automatic test_wrap();
        for (int n = 0; n < 17; n++) run_instr(OP_J, 6'($urandom), 0, 0);
        n_chk++;
        if (cnt1 !== 4'd1) begin
            n_fail++; $display("FAIL wrap4: got %0d expected 1", cnt1);
        end
        n_chk++;
        if (cnt0 !== 32'd17) begin
            n_fail++; $display("FAIL wrap32: got %0d expected 17", cnt0);
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_add();
        test_lw_stall();
        test_branches();
        test_bad_instr();
        test_random();
        test_reset_midwait();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
